// File: rtl/cpu_isa_pkg.sv
// ISA constants and the control-bundle type shared by the decode stage and its decoder.
package cpu_isa_pkg;

  localparam int ISA_INSTR_W = 9;
  localparam int ISA_OP_W    = 5;
  localparam int ISA_REG_AW  = 4;
  localparam int ISA_ALUOP_W = 4;

  localparam logic [4:0] OP_ADD       = 5'd0;
  localparam logic [4:0] OP_SUB       = 5'd1;
  localparam logic [4:0] OP_MV        = 5'd2;
  localparam logic [4:0] OP_MV_TO_MATH = 5'd3;
  localparam logic [4:0] OP_MV_TO_CNT = 5'd4;
  localparam logic [4:0] OP_SET_ADR   = 5'd5;
  localparam logic [4:0] OP_MV_ADR    = 5'd6;
  localparam logic [4:0] OP_MV_MATH   = 5'd7;
  localparam logic [4:0] OP_MV_CNT    = 5'd8;
  localparam logic [4:0] OP_MATH_TO_ADR = 5'd9;
  localparam logic [4:0] OP_RS_ADR    = 5'd10;
  localparam logic [4:0] OP_RS_CNT    = 5'd11;
  localparam logic [4:0] OP_SETI      = 5'd12;
  localparam logic [4:0] OP_SET_REG   = 5'd13;
  localparam logic [4:0] OP_SET_CNT   = 5'd14;
  localparam logic [4:0] OP_BE        = 5'd15;
  localparam logic [4:0] OP_BNE       = 5'd16;
  localparam logic [4:0] OP_BEZ       = 5'd17;
  localparam logic [4:0] OP_BLTZ      = 5'd18;
  localparam logic [4:0] OP_BGTE      = 5'd19;
  localparam logic [4:0] OP_EVU       = 5'd20;
  localparam logic [4:0] OP_EVL       = 5'd21;
  localparam logic [4:0] OP_LD        = 5'd22;
  localparam logic [4:0] OP_ST        = 5'd23;
  localparam logic [4:0] OP_JUMP      = 5'd24;
  localparam logic [4:0] OP_ZERO_REG  = 5'd25;
  localparam logic [4:0] OP_HALT      = 5'd26;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_EVU = 4'd2;
  localparam logic [3:0] ALU_EVL = 4'd3;
  localparam logic [3:0] ALU_GTE = 4'd4;
  localparam logic [3:0] ALU_LTZ = 4'd5;
  localparam logic [3:0] ALU_EZ  = 4'd6;
  localparam logic [3:0] ALU_EQ  = 4'd7;
  localparam logic [3:0] ALU_NE  = 4'd8;

  localparam logic [3:0] REG_ADR  = 4'd4;
  localparam logic [3:0] REG_MATH = 4'd5;
  localparam logic [3:0] REG_CNT  = 4'd7;

  typedef struct packed {
    logic [ISA_REG_AW-1:0]  read_reg0;
    logic [ISA_REG_AW-1:0]  read_reg1;
    logic [ISA_REG_AW-1:0]  write_reg;
    logic                   write_en;
    logic                   move;
    logic                   mem_to_reg;
    logic                   mem_write;
    logic                   branch;
    logic                   jump_sign;
    logic                   immediate;
    logic                   set_quarter;
    logic [ISA_ALUOP_W-1:0] alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} stage_state_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side handshake, EX-side control bundle and status of the decode stage.
interface decode_stage_if #(
  parameter int INSTR_W = 9,
  parameter int REG_AW  = 4,
  parameter int ALUOP_W = 4
) ();
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_in;
  logic               instr_ready;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [REG_AW-1:0]  read_reg0;
  logic [REG_AW-1:0]  read_reg1;
  logic [REG_AW-1:0]  write_reg;
  logic               write_en;
  logic               move;
  logic               mem_to_reg;
  logic               mem_write;
  logic               branch;
  logic               jump_sign;
  logic               immediate;
  logic               set_quarter;
  logic [ALUOP_W-1:0] alu_op;
  logic               halted;
  logic               illegal;
  logic [15:0]        stall_count;

  modport master (
    output instr_valid, instr_in, flush, out_ready,
    input  instr_ready, out_valid, read_reg0, read_reg1, write_reg, write_en, move,
           mem_to_reg, mem_write, branch, jump_sign, immediate, set_quarter, alu_op,
           halted, illegal, stall_count
  );

  modport slave (
    input  instr_valid, instr_in, flush, out_ready,
    output instr_ready, out_valid, read_reg0, read_reg1, write_reg, write_en, move,
           mem_to_reg, mem_write, branch, jump_sign, immediate, set_quarter, alu_op,
           halted, illegal, stall_count
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational opcode-to-control decode; unlisted fields stay 0, reserved opcodes give a NOP.
module instr_decoder
  import cpu_isa_pkg::*;
#(
  parameter int INSTR_W = ISA_INSTR_W,
  parameter int OP_W    = ISA_OP_W
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl,
  output logic               reads_r1,
  output logic               is_halt,
  output logic               illegal
);

  logic [OP_W-1:0] op;
  logic [3:0]      ra;
  logic [3:0]      rb;

  assign op = instr[INSTR_W-1 -: OP_W];
  assign ra = {2'b00, instr[3:2]};
  assign rb = {2'b00, instr[1:0]};

  always_comb begin
    ctrl     = '0;
    reads_r1 = 1'b0;
    is_halt  = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        ctrl.read_reg0 = ra;  ctrl.read_reg1 = REG_MATH;  ctrl.write_reg = rb;
        ctrl.write_en  = 1'b1;
        ctrl.alu_op    = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
        reads_r1       = 1'b1;
      end
      OP_MV, OP_MV_TO_MATH, OP_MV_TO_CNT, OP_SET_ADR: begin
        ctrl.move = 1'b1;  ctrl.write_en = 1'b1;  ctrl.read_reg0 = ra;
        case (op)
          OP_MV_TO_MATH: ctrl.write_reg = REG_MATH;
          OP_MV_TO_CNT:  ctrl.write_reg = REG_CNT;
          OP_SET_ADR:    ctrl.write_reg = REG_ADR;
          default:       ctrl.write_reg = rb;
        endcase
      end
      OP_MV_ADR:      begin ctrl.move = 1'b1; ctrl.write_en = 1'b1; ctrl.read_reg0 = REG_ADR;  ctrl.write_reg = rb; end
      OP_MV_MATH:     begin ctrl.move = 1'b1; ctrl.write_en = 1'b1; ctrl.read_reg0 = REG_MATH; ctrl.write_reg = rb; end
      OP_MV_CNT:      begin ctrl.move = 1'b1; ctrl.write_en = 1'b1; ctrl.read_reg0 = REG_CNT;  ctrl.write_reg = rb; end
      OP_MATH_TO_ADR: begin ctrl.move = 1'b1; ctrl.write_en = 1'b1; ctrl.read_reg0 = REG_MATH; ctrl.write_reg = REG_ADR; end
      OP_RS_ADR: begin
        ctrl.immediate = 1'b1;  ctrl.write_en = 1'b1;  ctrl.write_reg = REG_ADR;
        ctrl.jump_sign = instr[0];
      end
      OP_RS_CNT: begin ctrl.immediate = 1'b1; ctrl.write_en = 1'b1; ctrl.write_reg = REG_CNT; end
      OP_SETI: begin
        ctrl.immediate = 1'b1;  ctrl.write_en = 1'b1;
        ctrl.read_reg0 = instr[3:0];  ctrl.write_reg = REG_MATH;
      end
      OP_SET_REG: begin
        ctrl.move = 1'b1;  ctrl.set_quarter = 1'b1;  ctrl.write_en = 1'b1;
        ctrl.read_reg0 = REG_MATH;  ctrl.read_reg1 = ra;  ctrl.write_reg = rb;
        reads_r1 = 1'b1;
      end
      OP_SET_CNT: begin
        ctrl.set_quarter = 1'b1;  ctrl.write_en = 1'b1;
        ctrl.read_reg0 = rb;  ctrl.read_reg1 = ra;  ctrl.write_reg = REG_CNT;
        reads_r1 = 1'b1;
      end
      OP_BE, OP_BNE, OP_BEZ, OP_BLTZ, OP_BGTE: begin
        ctrl.branch = 1'b1;  ctrl.read_reg0 = ra;  ctrl.read_reg1 = rb;
        reads_r1 = 1'b1;
        case (op)
          OP_BE:   ctrl.alu_op = ALU_EQ;
          OP_BNE:  ctrl.alu_op = ALU_NE;
          OP_BEZ:  ctrl.alu_op = ALU_EZ;
          OP_BLTZ: ctrl.alu_op = ALU_LTZ;
          default: ctrl.alu_op = ALU_GTE;
        endcase
      end
      OP_EVU: begin ctrl.read_reg0 = ra; ctrl.alu_op = ALU_EVU; end
      OP_EVL: begin ctrl.read_reg0 = ra; ctrl.alu_op = ALU_EVL; end
      OP_LD: begin
        ctrl.write_en = 1'b1;  ctrl.mem_to_reg = 1'b1;
        ctrl.read_reg0 = ra;  ctrl.read_reg1 = REG_ADR;  ctrl.write_reg = rb;
        ctrl.alu_op = ALU_ADD;
        reads_r1 = 1'b1;
      end
      OP_ST: begin
        ctrl.mem_write = 1'b1;  ctrl.read_reg0 = ra;  ctrl.read_reg1 = REG_ADR;
        ctrl.alu_op = ALU_ADD;
        reads_r1 = 1'b1;
      end
      OP_JUMP:     begin ctrl.branch = 1'b1; ctrl.alu_op = ALU_EQ; end
      OP_ZERO_REG: begin ctrl.immediate = 1'b1; ctrl.write_en = 1'b1; ctrl.write_reg = rb; end
      OP_HALT:     is_halt = 1'b1;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: handshakes, load-use stall, flush, halt FSM, sticky illegal flag.
// Build option DECODE_STALL_CNT_EN adds a saturating stall-cycle counter.
//
// state     | meaning
// ST_RUN    | accepting instructions
// ST_DRAIN  | halt accepted, waiting for EX to consume it
// ST_HALTED | stopped until reset
module decode_stage
  import cpu_isa_pkg::*;
#(
  parameter int INSTR_W = ISA_INSTR_W,
  parameter int OP_W    = ISA_OP_W,
  parameter int REG_AW  = ISA_REG_AW,
  parameter int ALUOP_W = ISA_ALUOP_W
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  stage_state_t state_q, state_d;
  ctrl_t        bundle_q, bundle_d, dec_ctrl;
  logic         out_valid_q, out_valid_d;
  logic         illegal_q, illegal_d;
  logic         dec_reads_r1, dec_is_halt, dec_illegal;
  logic         stall, instr_ready, accept;

  instr_decoder #(.INSTR_W(INSTR_W), .OP_W(OP_W)) u_decoder (
    .instr    (bus.instr_in),
    .ctrl     (dec_ctrl),
    .reads_r1 (dec_reads_r1),
    .is_halt  (dec_is_halt),
    .illegal  (dec_illegal)
  );

  // A held load whose destination feeds the incoming instruction must leave EX first.
  assign stall = out_valid_q && bundle_q.mem_to_reg && bus.instr_valid &&
                 ((dec_ctrl.read_reg0 == bundle_q.write_reg) ||
                  (dec_reads_r1 && (dec_ctrl.read_reg1 == bundle_q.write_reg)));

  assign instr_ready = (state_q == ST_RUN) && !stall && !bus.flush &&
                       (!out_valid_q || bus.out_ready);
  assign accept      = bus.instr_valid && instr_ready;

  always_comb begin
    state_d     = state_q;
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    illegal_d   = illegal_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      bundle_d    = dec_ctrl;
      illegal_d   = illegal_q | dec_illegal;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      ST_RUN:    if (accept && dec_is_halt) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.flush)                          state_d = ST_RUN;
        else if (out_valid_q && bus.out_ready)  state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (bus.instr_valid && !instr_ready && (state_q == ST_RUN) &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.stall_count = '0;
`endif

  assign bus.instr_ready = instr_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.read_reg0   = REG_AW'(bundle_q.read_reg0);
  assign bus.read_reg1   = REG_AW'(bundle_q.read_reg1);
  assign bus.write_reg   = REG_AW'(bundle_q.write_reg);
  assign bus.write_en    = bundle_q.write_en;
  assign bus.move        = bundle_q.move;
  assign bus.mem_to_reg  = bundle_q.mem_to_reg;
  assign bus.mem_write   = bundle_q.mem_write;
  assign bus.branch      = bundle_q.branch;
  assign bus.jump_sign   = bundle_q.jump_sign;
  assign bus.immediate   = bundle_q.immediate;
  assign bus.set_quarter = bundle_q.set_quarter;
  assign bus.alu_op      = ALUOP_W'(bundle_q.alu_op);
  assign bus.halted      = (state_q == ST_HALTED);
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected bundles queued on accept, compared on consume.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if ifc ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          last_wait = 0;
  bit          stop_rnd = 1'b0;
  logic [23:0] sb_q[$];
  logic [23:0] obs;
  logic [15:0] sc0;

  assign obs = {ifc.read_reg0, ifc.read_reg1, ifc.write_reg, ifc.write_en, ifc.move,
                ifc.mem_to_reg, ifc.mem_write, ifc.branch, ifc.jump_sign, ifc.immediate,
                ifc.set_quarter, ifc.alu_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode: {r0, r1, wr, we, mv, m2r, mw, br, js, imm, sq, alu}
  function automatic logic [23:0] ref_dec(input logic [8:0] i);
    logic [3:0] r0, r1, wr, alu, a, b;
    logic we, mv, m2r, mw, br, js, imm, sq;
    {r0, r1, wr, alu} = '0;
    {we, mv, m2r, mw, br, js, imm, sq} = '0;
    a = {2'b00, i[3:2]};
    b = {2'b00, i[1:0]};
    case (i[8:4])
      5'd0:  begin r0 = a; r1 = 4'd5; wr = b; we = 1; alu = 4'd0; end
      5'd1:  begin r0 = a; r1 = 4'd5; wr = b; we = 1; alu = 4'd1; end
      5'd2:  begin mv = 1; we = 1; r0 = a; wr = b; end
      5'd3:  begin mv = 1; we = 1; r0 = a; wr = 4'd5; end
      5'd4:  begin mv = 1; we = 1; r0 = a; wr = 4'd7; end
      5'd5:  begin mv = 1; we = 1; r0 = a; wr = 4'd4; end
      5'd6:  begin mv = 1; we = 1; r0 = 4'd4; wr = b; end
      5'd7:  begin mv = 1; we = 1; r0 = 4'd5; wr = b; end
      5'd8:  begin mv = 1; we = 1; r0 = 4'd7; wr = b; end
      5'd9:  begin mv = 1; we = 1; r0 = 4'd5; wr = 4'd4; end
      5'd10: begin imm = 1; we = 1; wr = 4'd4; js = i[0]; end
      5'd11: begin imm = 1; we = 1; wr = 4'd7; end
      5'd12: begin imm = 1; we = 1; r0 = i[3:0]; wr = 4'd5; end
      5'd13: begin mv = 1; sq = 1; we = 1; r0 = 4'd5; r1 = a; wr = b; end
      5'd14: begin sq = 1; we = 1; r0 = b; r1 = a; wr = 4'd7; end
      5'd15: begin br = 1; r0 = a; r1 = b; alu = 4'd7; end
      5'd16: begin br = 1; r0 = a; r1 = b; alu = 4'd8; end
      5'd17: begin br = 1; r0 = a; r1 = b; alu = 4'd6; end
      5'd18: begin br = 1; r0 = a; r1 = b; alu = 4'd5; end
      5'd19: begin br = 1; r0 = a; r1 = b; alu = 4'd4; end
      5'd20: begin r0 = a; alu = 4'd2; end
      5'd21: begin r0 = a; alu = 4'd3; end
      5'd22: begin we = 1; m2r = 1; r0 = a; r1 = 4'd4; wr = b; alu = 4'd0; end
      5'd23: begin mw = 1; r0 = a; r1 = 4'd4; alu = 4'd0; end
      5'd24: begin br = 1; alu = 4'd7; end
      5'd25: begin imm = 1; we = 1; wr = b; end
      default: ;
    endcase
    return {r0, r1, wr, we, mv, m2r, mw, br, js, imm, sq, alu};
  endfunction

  always @(negedge clk) begin
    if (!rst_n || ifc.flush) begin
      sb_q.delete();
    end else begin
      if (ifc.out_valid && ifc.out_ready) begin
        if (sb_q.size() == 0) check("sb_depth", 32'(sb_q.size()), 32'd1);
        else                  check("bundle", 32'(obs), 32'(sb_q.pop_front()));
      end
      if (ifc.instr_valid && ifc.instr_ready) sb_q.push_back(ref_dec(ifc.instr_in));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [8:0] ins);
    bit ok = 1'b0;
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = ins;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ifc.instr_ready) begin
        ok = 1'b1;
        last_wait = k;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    ifc.instr_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifc.instr_valid = 1'b0;
    ifc.instr_in    = '0;
    ifc.flush       = 1'b0;
    ifc.out_ready   = 1'b1;

    // reset state
    tick(2);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_bundle", 32'(obs), 32'd0);
    check("rst_halted", 32'(ifc.halted), 32'd0);
    check("rst_illegal", 32'(ifc.illegal), 32'd0);
    check("rst_stall_cnt", 32'(ifc.stall_count), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("idle_ready", 32'(ifc.instr_ready), 32'd1);

    // back-to-back add/sub
    send(9'b0_0000_01_10);
    check("add_valid", 32'(ifc.out_valid), 32'd1);
    check("add_r0", 32'(ifc.read_reg0), 32'd1);
    check("add_r1", 32'(ifc.read_reg1), 32'd5);
    check("add_wr", 32'(ifc.write_reg), 32'd2);
    for (int n = 0; n < 6; n++) begin
      send({4'b0000, 1'(n & 1), 4'($urandom_range(0, 15))});
      check("b2b_wait", 32'(last_wait), 32'd0);
    end

    // load-use stall through r0
    send({5'd22, 2'd1, 2'd0});
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = {5'd0, 2'd0, 2'd1};
    #1;
    check("stall_r0_ready", 32'(ifc.instr_ready), 32'd0);
    sc0 = ifc.stall_count;
    tick(1);
    check("bubble_valid", 32'(ifc.out_valid), 32'd0);
    check("after_bubble_ready", 32'(ifc.instr_ready), 32'd1);
`ifdef DECODE_STALL_CNT_EN
    check("stall_cnt", 32'(ifc.stall_count), 32'(sc0 + 16'd1));
`else
    check("stall_cnt_off", 32'(ifc.stall_count), 32'd0);
`endif
    tick(1);
    check("after_stall_valid", 32'(ifc.out_valid), 32'd1);
    check("after_stall_r0", 32'(ifc.read_reg0), 32'd0);
    ifc.instr_valid = 1'b0;

    // stall through r1 (setReg reads i[3:2] as r1)
    send({5'd22, 2'd0, 2'd2});
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = {5'd13, 2'd2, 2'd1};
    #1;
    check("stall_r1_ready", 32'(ifc.instr_ready), 32'd0);
    send({5'd13, 2'd2, 2'd1});
    check("stall_r1_wait", 32'(last_wait), 32'd1);

    // evu does not read r1, so its zero r1 field must not collide with ld's wr=0
    send({5'd22, 2'd1, 2'd0});
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = {5'd20, 2'd1, 2'd0};
    #1;
    check("no_stall_ready", 32'(ifc.instr_ready), 32'd1);
    send({5'd20, 2'd1, 2'd0});
    tick(1);

    // backpressure holding bne
    ifc.out_ready = 1'b0;
    send({5'd16, 2'd3, 2'd1});
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = {5'd1, 2'd2, 2'd3};
    for (int n = 0; n < 3; n++) begin
      #1;
      check("hold_valid", 32'(ifc.out_valid), 32'd1);
      check("hold_branch", 32'(ifc.branch), 32'd1);
      check("hold_alu", 32'(ifc.alu_op), 32'd8);
      check("hold_r0", 32'(ifc.read_reg0), 32'd3);
      check("hold_ready", 32'(ifc.instr_ready), 32'd0);
      tick(1);
    end
    ifc.out_ready = 1'b1;
    send({5'd1, 2'd2, 2'd3});
    tick(1);

    // halt: drain then halted, input ignored
    send({5'd26, 4'd0});
    check("drain_halted", 32'(ifc.halted), 32'd0);
    check("drain_ready", 32'(ifc.instr_ready), 32'd0);
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = {5'd0, 4'd5};
    tick(1);
    check("halted", 32'(ifc.halted), 32'd1);
    for (int n = 0; n < 3; n++) begin
      check("halted_ready", 32'(ifc.instr_ready), 32'd0);
      check("halted_valid", 32'(ifc.out_valid), 32'd0);
      tick(1);
    end
    ifc.flush = 1'b1;
    tick(1);
    ifc.flush = 1'b0;
    check("halted_flush", 32'(ifc.halted), 32'd1);
    ifc.instr_valid = 1'b0;
    rst_n = 1'b0;
    tick(1);
    check("halt_rst", 32'(ifc.halted), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("halt_rst_ready", 32'(ifc.instr_ready), 32'd1);

    // halt flushed while draining
    ifc.out_ready = 1'b0;
    send({5'd26, 4'd0});
    ifc.flush     = 1'b1;
    ifc.out_ready = 1'b1;
    #1;
    check("flush_ready", 32'(ifc.instr_ready), 32'd0);
    tick(1);
    ifc.flush = 1'b0;
    #1;
    check("flush_valid", 32'(ifc.out_valid), 32'd0);
    check("flush_ready_after", 32'(ifc.instr_ready), 32'd1);
    tick(2);
    check("flush_not_halted", 32'(ifc.halted), 32'd0);

    // flush kills held bundle and same-cycle instruction
    ifc.out_ready = 1'b0;
    send({5'd0, 4'd6});
    ifc.instr_valid = 1'b1;
    ifc.instr_in    = {5'd1, 4'd9};
    ifc.flush       = 1'b1;
    ifc.out_ready   = 1'b1;
    tick(1);
    ifc.flush       = 1'b0;
    ifc.instr_valid = 1'b0;
    #1;
    check("flush_kill_valid", 32'(ifc.out_valid), 32'd0);

    // illegal opcode, sticky through random traffic
    send({5'b11100, 4'hA});
    check("illegal_set", 32'(ifc.illegal), 32'd1);
    check("illegal_valid", 32'(ifc.out_valid), 32'd1);
    check("illegal_nop", 32'(obs), 32'd0);
    fork
      begin
        for (int n = 0; n < 60; n++)
          send({5'($urandom_range(0, 25)), 4'($urandom_range(0, 15))});
        stop_rnd = 1'b1;
      end
      begin
        while (!stop_rnd) begin
          ifc.out_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    ifc.out_ready = 1'b1;
    tick(3);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("illegal_sticky", 32'(ifc.illegal), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("illegal_rst", 32'(ifc.illegal), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // lowest reserved opcode
    send({5'b11011, 4'h0});
    check("illegal_11011", 32'(ifc.illegal), 32'd1);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined, parametrised successor to the combinational control decoder.
- Decodes one instruction per cycle into a registered control bundle for EX.
- Adds valid/ready handshakes, load-use stall, flush, a halt state machine and illegal-opcode detection.
- Sits between the fetch stage and EX; every output field is fully defined for every opcode, so no latches are inferred.

Parameters:
INSTR_W, 9, instruction width
OP_W, 5, opcode width (opcode = instr_in[INSTR_W-1 -: OP_W])
REG_AW, 4, register-index width
ALUOP_W, 4, ALU operation code width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, synchronous, active-low
instr_valid  in  1  fetch presents instruction
instr_in  in  INSTR_W  instruction word
instr_ready  out  1  stage accepts instruction this cycle
flush  in  1  kill the held output and any same-cycle accept
out_valid  out  1  control bundle valid toward EX
out_ready  in  1  EX consumes bundle
read_reg0, read_reg1, write_reg  out  REG_AW each  register indices
write_en, move, mem_to_reg, mem_write, branch, jump_sign, immediate, set_quarter  out  1 each  control flags
alu_op  out  ALUOP_W  ALU operation
halted  out  1  stage has halted
illegal  out  1  sticky illegal-opcode flag
stall_count  out  16  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at edge): out_valid=0, every bundle field=0, halted=0, illegal=0, stall_count=0, FSM=RUN.
- Latency: 1 cycle. The accept edge loads the bundle, and out_valid rises on the same edge.
- instr_ready = (FSM==RUN) && !stall && !flush && (!out_valid || out_ready).
- Accept = instr_valid && instr_ready.
- Bundle holding: the bundle is held stable while out_valid && !out_ready.
- Bundle clearing: when a bundle is consumed with no new accept, out_valid goes to 0.
- Decode constants: special registers ADR=4, MATH=5, CNT=7. ALU codes: ADD=0, SUB=1, EVU=2, EVL=3, GTE=4, LTZ=5, EZ=6, EQ=7, NE=8.
- Decode rule for unlisted fields: any field not listed for an opcode is 0.
- Decode table:
  - add/sub: r0=i[3:2], r1=MATH, wr=i[1:0], write_en=1, alu=ADD/SUB.
  - mv/mvToMath/mvToCnt/setAdr: move=1, write_en=1, r0=i[3:2], wr = i[1:0] / MATH / CNT / ADR respectively.
  - mvAdr/mvMath/mvCnt/mathToAdr: move=1, write_en=1, r0 = ADR / MATH / CNT / MATH, wr = i[1:0] / i[1:0] / i[1:0] / ADR.
  - rsAdr: immediate=1, write_en=1, wr=ADR, jump_sign=i[0].
  - rsCnt: immediate=1, write_en=1, wr=CNT.
  - seti: immediate=1, write_en=1, r0=i[3:0], wr=MATH.
  - setReg: move=1, set_quarter=1, write_en=1, r0=MATH, r1=i[3:2], wr=i[1:0].
  - setCnt: set_quarter=1, write_en=1, r0=i[1:0], r1=i[3:2], wr=CNT.
  - be/bne/bez/bltz/bgte: branch=1, r0=i[3:2], r1=i[1:0], alu = EQ / NE / EZ / LTZ / GTE.
  - evu/evl: r0=i[3:2], alu=EVU/EVL.
  - ld: write_en=1, mem_to_reg=1, r0=i[3:2], r1=ADR, wr=i[1:0], alu=ADD.
  - st: mem_write=1, r0=i[3:2], r1=ADR, alu=ADD.
  - jump: branch=1, alu=EQ.
  - zeroReg: immediate=1, write_en=1, wr=i[1:0].
  - halt: all flags 0.
  - opcodes 11011..11111: illegal; decoded as NOP bundle (still passed with out_valid=1); illegal set to 1 until reset.
- Load-use stall: stall = out_valid && mem_to_reg && instr_valid && (incoming r0==write_reg || incoming r1 reads a register and r1==write_reg).
  - While stalled and out_ready=1, the load is consumed and a bubble follows (out_valid=0 for 1 cycle).
  - The instruction is accepted on the next cycle.
- Halt FSM:
  - RUN -> DRAIN on accepting halt.
  - DRAIN -> HALTED when the halt bundle is consumed.
  - HALTED is terminal until reset; halted=1 only in HALTED.
  - instr_ready=0 in DRAIN and HALTED.
- Flush:
  - Next cycle out_valid=0; the same-cycle accept is discarded.
  - A flushed halt returns the FSM to RUN; flush in HALTED has no effect.
  - Flush has priority over stall and out_ready.
- Reset mid-operation: reset overrides everything, including DRAIN/HALTED.

Optional Feature:
- Macro: DECODE_STALL_CNT_EN.
- Defined: stall_count increments each cycle where instr_valid && !instr_ready && FSM==RUN. It saturates at 16'hFFFF and clears on reset.
- Undefined: stall_count is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package cpu_isa_pkg: opcode constants, ALU code constants, ADR/MATH/CNT indices, control-bundle struct typedef.
- Sub-module instr_decoder: purely combinational opcode-to-bundle decode, including the illegal flag.
- decode_stage owns the handshake, hazard, flush and FSM logic.

Test Plan:
- Back-to-back add (0_0000_01_10) with out_ready=1 -> out_valid next cycle, r0=1, r1=5, wr=2, write_en=1, alu=0, instr_ready stays 1.
- ld r0<-[r1] followed by add reading r0 -> one bubble cycle (out_valid=0), stall_count=1 with macro, then add issued.
- out_ready=0 for 3 cycles holding bne -> bundle stable (branch=1, alu=8), instr_ready=0 throughout.
- halt accepted, out_ready=1 -> DRAIN for 1 cycle, then halted=1; further instr_valid ignored until rst_n=0.
- halt accepted then flush in the same DRAIN cycle -> out_valid=0, FSM back to RUN, instr_ready=1.
- opcode 11100 -> NOP bundle, illegal=1 and stays 1 after later valid instructions; rst_n=0 clears it.
